// File: rtl/rv32i_decode_execute.sv
// rv32i_decode_execute: combinational RV32I decode, control and execute slice.
// The only state is a ready flag. Until the first clock edge with rst low has
// been seen, the slice presents a NOP with all fields and controls at zero.
module rv32i_decode_execute #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       insn_i,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] rs1data_i,
  input  logic [DWIDTH-1:0] rs2data_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [31:0]       insn_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        rd_o,
  output logic [2:0]        funct3_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [6:0]        funct7_o,
  output logic [4:0]        shamt_o,
  output logic [31:0]       imm_o,
  output logic              pcsel_o,
  output logic              immsel_o,
  output logic              rs2sel_o,
  output logic              rs1sel_o,
  output logic              regwren_o,
  output logic              memren_o,
  output logic              memwren_o,
  output logic [1:0]        wbsel_o,
  output logic [3:0]        alusel_o,
  output logic [DWIDTH-1:0] res_o,
  output logic              brtaken_o
);

  // Opcodes
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;

  // ALU operations
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Map funct3 (plus the funct7[5] alternate bit) to an ALU operation.
  // SUB exists only for register-register ops; immediate ops ignore the bit
  // except for the right-shift SRA/SRL choice.
  function automatic logic [3:0] arith_op(input logic [2:0] f3,
                                          input logic       alt,
                                          input logic       is_reg);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  logic              ready_r;
  logic [6:0]        opcode_s;
  logic [2:0]        funct3_s;
  logic [6:0]        funct7_s;
  logic [31:0]       imm_s;
  logic              pcsel_s;
  logic              immsel_s;
  logic              rs2sel_s;
  logic              rs1sel_s;
  logic              regwren_s;
  logic              memren_s;
  logic              memwren_s;
  logic [1:0]        wbsel_s;
  logic [3:0]        alusel_s;
  logic              res_en_s;
  logic              is_branch_s;
  logic              is_jump_s;
  logic              is_jalr_s;
  logic              cond_s;
  logic [DWIDTH-1:0] op_a_s;
  logic [DWIDTH-1:0] op_b_s;
  logic [4:0]        sh_s;
  logic [DWIDTH-1:0] alu_s;
  logic [DWIDTH-1:0] res_s;
  logic              brtaken_s;

  assign opcode_s = insn_i[6:0];
  assign funct3_s = insn_i[14:12];
  assign funct7_s = insn_i[31:25];

  // Ready flag: cleared by reset, set on the first edge with reset low.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_r <= 1'b0;
    end else begin
      ready_r <= 1'b1;
    end
  end

  // Opcode decode: immediate format, datapath controls and ALU operation.
  always_comb begin
    imm_s       = 32'h0000_0000;
    pcsel_s     = 1'b0;
    immsel_s    = 1'b0;
    rs2sel_s    = 1'b0;
    rs1sel_s    = 1'b0;
    regwren_s   = 1'b0;
    memren_s    = 1'b0;
    memwren_s   = 1'b0;
    wbsel_s     = 2'd0;
    alusel_s    = ALU_ADD;
    res_en_s    = 1'b0;
    is_branch_s = 1'b0;
    is_jump_s   = 1'b0;
    is_jalr_s   = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        regwren_s = 1'b1;
        res_en_s  = 1'b1;
        alusel_s  = arith_op(funct3_s, funct7_s[5], 1'b1);
      end
      OPC_OPIMM: begin
        imm_s     = {{20{insn_i[31]}}, insn_i[31:20]};
        regwren_s = 1'b1;
        immsel_s  = 1'b1;
        rs2sel_s  = 1'b1;
        res_en_s  = 1'b1;
        alusel_s  = arith_op(funct3_s, funct7_s[5], 1'b0);
      end
      OPC_LOAD: begin
        imm_s     = {{20{insn_i[31]}}, insn_i[31:20]};
        regwren_s = 1'b1;
        memren_s  = 1'b1;
        immsel_s  = 1'b1;
        rs2sel_s  = 1'b1;
        wbsel_s   = 2'd1;
        res_en_s  = 1'b1;
      end
      OPC_STORE: begin
        imm_s     = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
        memwren_s = 1'b1;
        immsel_s  = 1'b1;
        rs2sel_s  = 1'b1;
        res_en_s  = 1'b1;
      end
      OPC_BRANCH: begin
        imm_s       = {{20{insn_i[31]}}, insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
        pcsel_s     = 1'b1;
        immsel_s    = 1'b1;
        rs1sel_s    = 1'b1;
        rs2sel_s    = 1'b1;
        res_en_s    = 1'b1;
        is_branch_s = 1'b1;
      end
      OPC_JAL: begin
        imm_s     = {{12{insn_i[31]}}, insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};
        pcsel_s   = 1'b1;
        regwren_s = 1'b1;
        immsel_s  = 1'b1;
        rs1sel_s  = 1'b1;
        rs2sel_s  = 1'b1;
        wbsel_s   = 2'd2;
        res_en_s  = 1'b1;
        is_jump_s = 1'b1;
      end
      OPC_JALR: begin
        imm_s     = {{20{insn_i[31]}}, insn_i[31:20]};
        pcsel_s   = 1'b1;
        regwren_s = 1'b1;
        immsel_s  = 1'b1;
        rs2sel_s  = 1'b1;
        wbsel_s   = 2'd2;
        res_en_s  = 1'b1;
        is_jump_s = 1'b1;
        is_jalr_s = 1'b1;
      end
      OPC_LUI: begin
        imm_s     = {insn_i[31:12], 12'h000};
        regwren_s = 1'b1;
        immsel_s  = 1'b1;
        rs2sel_s  = 1'b1;
        alusel_s  = ALU_PASS_B;
        res_en_s  = 1'b1;
      end
      OPC_AUIPC: begin
        imm_s     = {insn_i[31:12], 12'h000};
        regwren_s = 1'b1;
        immsel_s  = 1'b1;
        rs1sel_s  = 1'b1;
        rs2sel_s  = 1'b1;
        res_en_s  = 1'b1;
      end
      default: begin
        // SYSTEM and unknown opcodes: everything stays at zero.
        res_en_s = 1'b0;
      end
    endcase
  end

  assign op_a_s = rs1sel_s ? DWIDTH'(pc_i) : rs1data_i;
  assign op_b_s = rs2sel_s ? DWIDTH'(imm_s) : rs2data_i;
  assign sh_s   = op_b_s[4:0];

  // ALU: 32-bit wrap-around arithmetic, shift amount from operand B[4:0].
  always_comb begin
    alu_s = {DWIDTH{1'b0}};
    case (alusel_s)
      ALU_ADD:    alu_s = op_a_s + op_b_s;
      ALU_SUB:    alu_s = op_a_s - op_b_s;
      ALU_SLL:    alu_s = op_a_s << sh_s;
      ALU_SLT:    alu_s = {{(DWIDTH-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
      ALU_SLTU:   alu_s = {{(DWIDTH-1){1'b0}}, (op_a_s < op_b_s)};
      ALU_XOR:    alu_s = op_a_s ^ op_b_s;
      ALU_SRL:    alu_s = op_a_s >> sh_s;
      ALU_SRA:    alu_s = $signed(op_a_s) >>> sh_s;
      ALU_OR:     alu_s = op_a_s | op_b_s;
      ALU_AND:    alu_s = op_a_s & op_b_s;
      ALU_PASS_B: alu_s = op_b_s;
      default:    alu_s = {DWIDTH{1'b0}};
    endcase
  end

  // Result select: JALR clears bit 0 of the target, inactive opcodes give zero.
  always_comb begin
    res_s = {DWIDTH{1'b0}};
    if (!res_en_s) begin
      res_s = {DWIDTH{1'b0}};
    end else if (is_jalr_s) begin
      res_s = alu_s & {{(DWIDTH-1){1'b1}}, 1'b0};
    end else begin
      res_s = alu_s;
    end
  end

  // Branch condition on the register operands; jumps are always taken.
  always_comb begin
    cond_s = 1'b0;
    case (funct3_s)
      3'b000:  cond_s = (rs1data_i == rs2data_i);
      3'b001:  cond_s = (rs1data_i != rs2data_i);
      3'b100:  cond_s = ($signed(rs1data_i) <  $signed(rs2data_i));
      3'b101:  cond_s = ($signed(rs1data_i) >= $signed(rs2data_i));
      3'b110:  cond_s = (rs1data_i <  rs2data_i);
      3'b111:  cond_s = (rs1data_i >= rs2data_i);
      default: cond_s = 1'b0;
    endcase
    if (is_jump_s) begin
      brtaken_s = 1'b1;
    end else if (is_branch_s) begin
      brtaken_s = cond_s;
    end else begin
      brtaken_s = 1'b0;
    end
  end

  assign pc_o = pc_i;

  // Output gating: until ready, present a NOP with every field and control at zero.
  always_comb begin
    if (ready_r) begin
      insn_o    = insn_i;
      opcode_o  = opcode_s;
      rd_o      = insn_i[11:7];
      funct3_o  = funct3_s;
      rs1_o     = insn_i[19:15];
      rs2_o     = insn_i[24:20];
      funct7_o  = funct7_s;
      shamt_o   = insn_i[24:20];
      imm_o     = imm_s;
      pcsel_o   = pcsel_s;
      immsel_o  = immsel_s;
      rs2sel_o  = rs2sel_s;
      rs1sel_o  = rs1sel_s;
      regwren_o = regwren_s;
      memren_o  = memren_s;
      memwren_o = memwren_s;
      wbsel_o   = wbsel_s;
      alusel_o  = alusel_s;
      res_o     = res_s;
      brtaken_o = brtaken_s;
    end else begin
      insn_o    = NOP_INSN;
      opcode_o  = 7'd0;
      rd_o      = 5'd0;
      funct3_o  = 3'd0;
      rs1_o     = 5'd0;
      rs2_o     = 5'd0;
      funct7_o  = 7'd0;
      shamt_o   = 5'd0;
      imm_o     = 32'h0000_0000;
      pcsel_o   = 1'b0;
      immsel_o  = 1'b0;
      rs2sel_o  = 1'b0;
      rs1sel_o  = 1'b0;
      regwren_o = 1'b0;
      memren_o  = 1'b0;
      memwren_o = 1'b0;
      wbsel_o   = 2'd0;
      alusel_o  = 4'd0;
      res_o     = {DWIDTH{1'b0}};
      brtaken_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32i_decode_execute.sv
// Directed testbench for rv32i_decode_execute with hand-computed expectations.
module tb_rv32i_decode_execute;

  logic        clk;
  logic        rst;
  logic [31:0] insn_i;
  logic [31:0] pc_i;
  logic [31:0] rs1data_i;
  logic [31:0] rs2data_i;
  logic [31:0] pc_o;
  logic [31:0] insn_o;
  logic [6:0]  opcode_o;
  logic [4:0]  rd_o;
  logic [2:0]  funct3_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [6:0]  funct7_o;
  logic [4:0]  shamt_o;
  logic [31:0] imm_o;
  logic        pcsel_o;
  logic        immsel_o;
  logic        rs2sel_o;
  logic        rs1sel_o;
  logic        regwren_o;
  logic        memren_o;
  logic        memwren_o;
  logic [1:0]  wbsel_o;
  logic [3:0]  alusel_o;
  logic [31:0] res_o;
  logic        brtaken_o;

  int checks = 0;
  int errors = 0;

  rv32i_decode_execute #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk(clk), .rst(rst), .insn_i(insn_i), .pc_i(pc_i),
    .rs1data_i(rs1data_i), .rs2data_i(rs2data_i), .pc_o(pc_o), .insn_o(insn_o),
    .opcode_o(opcode_o), .rd_o(rd_o), .funct3_o(funct3_o), .rs1_o(rs1_o),
    .rs2_o(rs2_o), .funct7_o(funct7_o), .shamt_o(shamt_o), .imm_o(imm_o),
    .pcsel_o(pcsel_o), .immsel_o(immsel_o), .rs2sel_o(rs2sel_o),
    .rs1sel_o(rs1sel_o), .regwren_o(regwren_o), .memren_o(memren_o),
    .memwren_o(memwren_o), .wbsel_o(wbsel_o), .alusel_o(alusel_o),
    .res_o(res_o), .brtaken_o(brtaken_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of all control outputs: {pcsel,immsel,rs2sel,rs1sel,regwren,memren,memwren,wbsel,alusel}
  function automatic logic [31:0] ctl(input logic pcs, input logic ims, input logic r2s,
                                      input logic r1s, input logic rw, input logic mr,
                                      input logic mw, input logic [1:0] wb, input logic [3:0] alu);
    return {19'd0, pcs, ims, r2s, r1s, rw, mr, mw, wb, alu};
  endfunction

  function automatic logic [31:0] ctl_obs();
    return ctl(pcsel_o, immsel_o, rs2sel_o, rs1sel_o, regwren_o, memren_o,
               memwren_o, wbsel_o, alusel_o);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [31:0] insn, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    insn_i = insn; pc_i = pc; rs1data_i = a; rs2data_i = b;
    #1;
  endtask

  initial begin
    rst = 1'b1; insn_i = 32'h0050_0093; pc_i = 32'h0000_0040;
    rs1data_i = 32'h0000_0100; rs2data_i = 32'h0000_0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Reset state
    chk("rst_insn",   insn_o, 32'h0000_0013);
    chk("rst_opcode", {25'd0, opcode_o}, 32'd0);
    chk("rst_rd",     {27'd0, rd_o}, 32'd0);
    chk("rst_imm",    imm_o, 32'd0);
    chk("rst_ctl",    ctl_obs(), 32'd0);
    chk("rst_res",    res_o, 32'd0);
    chk("rst_br",     {31'd0, brtaken_o}, 32'd0);
    chk("rst_pc",     pc_o, 32'h0000_0040);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // ADDI x1,x0,5
    chk("addi_imm",  imm_o, 32'd5);
    chk("addi_rd",   {27'd0, rd_o}, 32'd1);
    chk("addi_ctl",  ctl_obs(), ctl(1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,2'd0,4'd0));
    chk("addi_res",  res_o, 32'h0000_0105);
    chk("addi_insn", insn_o, 32'h0050_0093);

    // SUB x0,x1,x2
    apply(32'h4020_8033, 32'h0000_0044, 32'd5, 32'd7);
    chk("sub_ctl", ctl_obs(), ctl(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,4'd1));
    chk("sub_res", res_o, 32'hFFFF_FFFE);
    chk("sub_f7",  {25'd0, funct7_o}, 32'h20);
    chk("sub_imm", imm_o, 32'd0);

    // BEQ x1,x2,-4
    apply(32'hFE20_8EE3, 32'h0100_0010, 32'd3, 32'd3);
    chk("beq_br",  {31'd0, brtaken_o}, 32'd1);
    chk("beq_res", res_o, 32'h0100_000C);
    chk("beq_imm", imm_o, 32'hFFFF_FFFC);
    chk("beq_ctl", ctl_obs(), ctl(1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'd0,4'd0));
    apply(32'hFE20_8EE3, 32'h0100_0010, 32'd3, 32'd4);
    chk("beq_nt",  {31'd0, brtaken_o}, 32'd0);

    // BLTU x1,x2,8 / BLT x1,x2,8 with rs2 = all ones: unsigned vs signed
    apply(32'h0020_E463, 32'h0000_0100, 32'd1, 32'hFFFF_FFFF);
    chk("bltu_br",  {31'd0, brtaken_o}, 32'd1);
    chk("bltu_res", res_o, 32'h0000_0108);
    apply(32'h0020_C463, 32'h0000_0100, 32'd1, 32'hFFFF_FFFF);
    chk("blt_br",   {31'd0, brtaken_o}, 32'd0);

    // JAL x1,8
    apply(32'h0080_00EF, 32'h0100_0000, 32'd0, 32'd0);
    chk("jal_res", res_o, 32'h0100_0008);
    chk("jal_ctl", ctl_obs(), ctl(1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,2'd2,4'd0));
    chk("jal_br",  {31'd0, brtaken_o}, 32'd1);

    // JALR x0,0(x1): bit 0 cleared
    apply(32'h0000_8067, 32'h0100_0008, 32'h0100_0005, 32'd0);
    chk("jalr_res", res_o, 32'h0100_0004);
    chk("jalr_ctl", ctl_obs(), ctl(1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,2'd2,4'd0));
    chk("jalr_br",  {31'd0, brtaken_o}, 32'd1);

    // SRAI x1,x1,1
    apply(32'h4010_D093, 32'h0000_0000, 32'h8000_0000, 32'd0);
    chk("srai_res",   res_o, 32'hC000_0000);
    chk("srai_shamt", {27'd0, shamt_o}, 32'd1);
    chk("srai_alu",   {28'd0, alusel_o}, 32'd7);

    // ADDI x1,x0,1024: funct7[5]=1 must not select SUB
    apply(32'h4000_0093, 32'h0000_0000, 32'd1, 32'd0);
    chk("addi_nosub", res_o, 32'h0000_0401);

    // SLT x1,x1,x2: -1 < 1 signed
    apply(32'h0020_A0B3, 32'h0000_0000, 32'hFFFF_FFFF, 32'd1);
    chk("slt_res", res_o, 32'd1);
    chk("slt_alu", {28'd0, alusel_o}, 32'd3);

    // LUI x1,0x12345
    apply(32'h1234_50B7, 32'h0000_0000, 32'hDEAD_BEEF, 32'd0);
    chk("lui_res", res_o, 32'h1234_5000);
    chk("lui_imm", imm_o, 32'h1234_5000);
    chk("lui_ctl", ctl_obs(), ctl(1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,2'd0,4'd10));

    // AUIPC x1,1
    apply(32'h0000_1097, 32'h0100_0000, 32'd0, 32'd0);
    chk("auipc_res", res_o, 32'h0100_1000);
    chk("auipc_ctl", ctl_obs(), ctl(1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,2'd0,4'd0));

    // LW x1,-4(x2)
    apply(32'hFFC1_2083, 32'h0000_0000, 32'h0000_0100, 32'd0);
    chk("lw_ctl", ctl_obs(), ctl(1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,2'd1,4'd0));
    chk("lw_imm", imm_o, 32'hFFFF_FFFC);
    chk("lw_res", res_o, 32'h0000_00FC);

    // SW x1,4(x2)
    apply(32'h0011_2223, 32'h0000_0000, 32'h0000_0100, 32'h5555_5555);
    chk("sw_ctl", ctl_obs(), ctl(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,2'd0,4'd0));
    chk("sw_imm", imm_o, 32'd4);
    chk("sw_res", res_o, 32'h0000_0104);

    // ECALL: everything zero
    apply(32'h0000_0073, 32'h0000_0000, 32'h1234_5678, 32'h1111_1111);
    chk("ecall_ctl",  ctl_obs(), 32'd0);
    chk("ecall_res",  res_o, 32'd0);
    chk("ecall_br",   {31'd0, brtaken_o}, 32'd0);
    chk("ecall_imm",  imm_o, 32'd0);
    chk("ecall_insn", insn_o, 32'h0000_0073);

    // Mid-operation reset: live until the edge, zero after it, live again one edge after release
    apply(32'h0050_0093, 32'h0000_0080, 32'h0000_0010, 32'd0);
    rst = 1'b1;
    #1;
    chk("mrst_before", res_o, 32'h0000_0015);
    @(posedge clk);
    #1;
    chk("mrst_res",  res_o, 32'd0);
    chk("mrst_insn", insn_o, 32'h0000_0013);
    chk("mrst_pc",   pc_o, 32'h0000_0080);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_hold", {31'd0, regwren_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("mrst_live", res_o, 32'h0000_0015);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
